// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard arbiter for the 5-stage in-order core: merges load-use, cache-wait,
// branch-redirect and halt requests into per-stage enables/flushes plus perf counters.
module pipeline_stall_ctrl #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_use_stall,
  input  logic                 icache_wait,
  input  logic                 dcache_wait,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_target,
  input  logic                 halt_req,
  output logic                 pc_en,
  output logic                 pc_redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StRedirPend = 2'd1,
    StHalted    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       pend_target_q, pend_target_d;
  logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0]  flush_count_q, flush_count_d;

  logic pc_en_c, pc_redirect_c;
  logic if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, mem_wb_flush_c;
  logic flush_inc;

  always_comb begin
    state_d        = state_q;
    pend_target_d  = pend_target_q;
    pc_en_c        = 1'b0;
    pc_redirect_c  = 1'b0;
    if_id_en_c     = 1'b0;
    id_ex_en_c     = 1'b0;
    ex_mem_en_c    = 1'b0;
    mem_wb_en_c    = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    mem_wb_flush_c = 1'b0;
    flush_inc      = 1'b0;

    case (state_q)
      StRun, StRedirPend: begin
        if (halt_req && !dcache_wait) begin
          mem_wb_en_c    = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_flush_c  = 1'b1;
          mem_wb_flush_c = 1'b1;
          state_d        = StHalted;
        end else if (dcache_wait) begin
          // WB already retired its instruction this cycle; bubble it so it cannot retire twice.
          mem_wb_en_c    = 1'b1;
          mem_wb_flush_c = 1'b1;
          if_id_flush_c  = (state_q == StRedirPend);
          if (state_q == StRun && branch_taken) begin
            state_d       = StRedirPend;
            pend_target_d = branch_target;
            flush_inc     = 1'b1;
          end
        end else if (state_q == StRedirPend) begin
          if_id_flush_c = 1'b1;
          id_ex_en_c    = 1'b1;
          ex_mem_en_c   = 1'b1;
          mem_wb_en_c   = 1'b1;
          if (!icache_wait) begin
            pc_en_c       = 1'b1;
            pc_redirect_c = 1'b1;
            state_d       = StRun;
          end
        end else if (branch_taken) begin
          // ID holds a wrong-path instruction, so any load-use request is moot.
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          ex_mem_en_c   = 1'b1;
          mem_wb_en_c   = 1'b1;
          flush_inc     = 1'b1;
          if (!icache_wait) begin
            pc_en_c       = 1'b1;
            pc_redirect_c = 1'b1;
          end else begin
            state_d       = StRedirPend;
            pend_target_d = branch_target;
          end
        end else if (load_use_stall) begin
          id_ex_flush_c = 1'b1;
          ex_mem_en_c   = 1'b1;
          mem_wb_en_c   = 1'b1;
        end else if (icache_wait) begin
          if_id_flush_c = 1'b1;
          id_ex_en_c    = 1'b1;
          ex_mem_en_c   = 1'b1;
          mem_wb_en_c   = 1'b1;
        end else begin
          pc_en_c     = 1'b1;
          if_id_en_c  = 1'b1;
          id_ex_en_c  = 1'b1;
          ex_mem_en_c = 1'b1;
          mem_wb_en_c = 1'b1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (state_q != StHalted && !pc_en_c) begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    end
    if (flush_inc) begin
      flush_count_d = flush_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StRun;
      pend_target_q  <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pend_target_q  <= pend_target_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Reset forces every enable and flush low without waiting for a clock edge.
  always_comb begin
    pc_en        = reset ? 1'b0 : pc_en_c;
    pc_redirect  = reset ? 1'b0 : pc_redirect_c;
    if_id_en     = reset ? 1'b0 : if_id_en_c;
    id_ex_en     = reset ? 1'b0 : id_ex_en_c;
    ex_mem_en    = reset ? 1'b0 : ex_mem_en_c;
    mem_wb_en    = reset ? 1'b0 : mem_wb_en_c;
    if_id_flush  = reset ? 1'b0 : if_id_flush_c;
    id_ex_flush  = reset ? 1'b0 : id_ex_flush_c;
    mem_wb_flush = reset ? 1'b0 : mem_wb_flush_c;
    redirect_pc  = (state_q == StRedirPend) ? pend_target_q : branch_target;
    halted       = (state_q == StHalted);
    stall_cycles = stall_cycles_q;
    flush_count  = flush_count_q;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: fixed vector table, directed multi-cycle sequences and a
// randomized run against a rule-level reference model.
module tb_pipeline_stall_ctrl;
  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = 8;

  logic            clk, reset;
  logic            load_use_stall, icache_wait, dcache_wait, branch_taken, halt_req;
  logic [XLEN-1:0] branch_target, redirect_pc;
  logic            pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic            if_id_flush, id_ex_flush, mem_wb_flush, halted;
  logic [CW-1:0]   stall_cycles, flush_count;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic lu, ic, dc, br, hr;
    logic [63:0] tgt;
  } in_t;

  typedef struct packed {
    logic pc_en, pc_redirect;
    logic [63:0] redirect_pc;
    logic if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
  } ctl_t;

  // Table record: inputs {lu,ic,dc,br,hr}, enables {if_id,id_ex,ex_mem,mem_wb},
  // flushes {if_id,id_ex,mem_wb}, and counters/halted after one clock from reset.
  typedef struct packed {
    logic [4:0]  in;
    logic [63:0] tgt;
    logic        pc_en, redir;
    logic [3:0]  en;
    logic [2:0]  fl;
    logic [7:0]  stall, flush;
    logic        halted;
  } vec_t;

  pipeline_stall_ctrl #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_use_stall(load_use_stall),
    .icache_wait   (icache_wait),
    .dcache_wait   (dcache_wait),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .pc_en         (pc_en),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mem_wb_flush  (mem_wb_flush),
    .halted        (halted),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: 0 = running, 1 = redirect pending, 2 = halted.
  int         st;
  logic [63:0] mpend;
  logic [CW-1:0] mstall, mflush;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic set_in(input in_t i);
    load_use_stall = i.lu;
    icache_wait    = i.ic;
    dcache_wait    = i.dc;
    branch_taken   = i.br;
    halt_req       = i.hr;
    branch_target  = i.tgt;
  endtask

  function automatic in_t mk_in(input logic [4:0] b, input logic [63:0] t);
    in_t i;
    {i.lu, i.ic, i.dc, i.br, i.hr} = b;
    i.tgt = t;
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    st = 0; mpend = '0; mstall = '0; mflush = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(mk_in(5'b0, 64'h0));
    #1;
    reset = 1'b0;
    #1;
    model_reset();
  endtask

  // Enables are don't-care where the matching flush already forces a bubble.
  task automatic cmp_ctl(input string tag, input ctl_t e);
    chk({tag, ".pc_en"}, pc_en, e.pc_en);
    chk({tag, ".pc_redirect"}, pc_redirect, e.pc_redirect);
    if (e.pc_redirect) chk({tag, ".redirect_pc"}, redirect_pc, e.redirect_pc);
    if (!e.if_id_flush) chk({tag, ".if_id_en"}, if_id_en, e.if_id_en);
    if (!e.id_ex_flush) chk({tag, ".id_ex_en"}, id_ex_en, e.id_ex_en);
    chk({tag, ".ex_mem_en"}, ex_mem_en, e.ex_mem_en);
    chk({tag, ".mem_wb_en"}, mem_wb_en, e.mem_wb_en);
    chk({tag, ".if_id_flush"}, if_id_flush, e.if_id_flush);
    chk({tag, ".id_ex_flush"}, id_ex_flush, e.id_ex_flush);
    chk({tag, ".mem_wb_flush"}, mem_wb_flush, e.mem_wb_flush);
  endtask

  // Expected controls straight from the request priority list.
  function automatic ctl_t model_ctl(input in_t i);
    ctl_t c = '0;
    c.redirect_pc = (st == 1) ? mpend : i.tgt;
    if (st == 2) return c;
    if (i.hr && !i.dc) begin
      c.mem_wb_en = 1; c.if_id_flush = 1; c.id_ex_flush = 1; c.mem_wb_flush = 1;
    end else if (i.dc) begin
      c.mem_wb_en = 1; c.mem_wb_flush = 1; c.if_id_flush = (st == 1);
    end else if (st == 1) begin
      c.if_id_flush = 1; c.id_ex_en = 1; c.ex_mem_en = 1; c.mem_wb_en = 1;
      c.pc_en = !i.ic; c.pc_redirect = !i.ic;
    end else if (i.br) begin
      c.if_id_flush = 1; c.id_ex_flush = 1; c.ex_mem_en = 1; c.mem_wb_en = 1;
      c.pc_en = !i.ic; c.pc_redirect = !i.ic;
    end else if (i.lu) begin
      c.id_ex_flush = 1; c.ex_mem_en = 1; c.mem_wb_en = 1;
    end else if (i.ic) begin
      c.if_id_flush = 1; c.id_ex_en = 1; c.ex_mem_en = 1; c.mem_wb_en = 1;
    end else begin
      c.pc_en = 1; c.if_id_en = 1; c.id_ex_en = 1; c.ex_mem_en = 1; c.mem_wb_en = 1;
    end
    return c;
  endfunction

  task automatic model_step(input in_t i, input ctl_t e);
    if (st != 2) begin
      if (!e.pc_en) mstall = mstall + 1'b1;
      if (i.hr && !i.dc) st = 2;
      else if (i.dc) begin
        if (st == 0 && i.br) begin st = 1; mpend = i.tgt; mflush = mflush + 1'b1; end
      end else if (st == 1) begin
        if (!i.ic) st = 0;
      end else if (i.br) begin
        mflush = mflush + 1'b1;
        if (i.ic) begin st = 1; mpend = i.tgt; end
      end
    end
  endtask

  vec_t vecs[10];
  ctl_t ev;
  in_t  ri;

  initial begin
    vecs[0] = '{5'b00000, 64'h0,         1'b1, 1'b0, 4'b1111, 3'b000, 8'd0, 8'd0, 1'b0};
    vecs[1] = '{5'b10000, 64'h0,         1'b0, 1'b0, 4'b0011, 3'b010, 8'd1, 8'd0, 1'b0};
    vecs[2] = '{5'b01000, 64'h0,         1'b0, 1'b0, 4'b0111, 3'b100, 8'd1, 8'd0, 1'b0};
    vecs[3] = '{5'b00100, 64'h0,         1'b0, 1'b0, 4'b0001, 3'b001, 8'd1, 8'd0, 1'b0};
    vecs[4] = '{5'b10010, 64'h8000_0040, 1'b1, 1'b1, 4'b0011, 3'b110, 8'd0, 8'd1, 1'b0};
    vecs[5] = '{5'b01010, 64'h100,       1'b0, 1'b0, 4'b0011, 3'b110, 8'd1, 8'd1, 1'b0};
    vecs[6] = '{5'b00110, 64'h200,       1'b0, 1'b0, 4'b0001, 3'b001, 8'd1, 8'd1, 1'b0};
    vecs[7] = '{5'b00001, 64'h0,         1'b0, 1'b0, 4'b0001, 3'b111, 8'd1, 8'd0, 1'b1};
    vecs[8] = '{5'b00101, 64'h0,         1'b0, 1'b0, 4'b0001, 3'b001, 8'd1, 8'd0, 1'b0};
    vecs[9] = '{5'b11000, 64'h0,         1'b0, 1'b0, 4'b0011, 3'b010, 8'd1, 8'd0, 1'b0};

    reset = 1'b1;
    set_in(mk_in(5'b0, 64'h0));
    #2;
    chk("rst.pc_en", pc_en, 0);
    chk("rst.mem_wb_en", mem_wb_en, 0);
    chk("rst.if_id_en", if_id_en, 0);
    chk("rst.mem_wb_flush", mem_wb_flush, 0);
    chk("rst.halted", halted, 0);
    chk("rst.stall", stall_cycles, 0);
    chk("rst.flush", flush_count, 0);

    for (int k = 0; k < 10; k++) begin
      do_reset();
      set_in(mk_in(vecs[k].in, vecs[k].tgt));
      ev.pc_en = vecs[k].pc_en;
      ev.pc_redirect = vecs[k].redir;
      ev.redirect_pc = vecs[k].tgt;
      {ev.if_id_en, ev.id_ex_en, ev.ex_mem_en, ev.mem_wb_en} = vecs[k].en;
      {ev.if_id_flush, ev.id_ex_flush, ev.mem_wb_flush} = vecs[k].fl;
      #1;
      cmp_ctl($sformatf("vec%0d", k), ev);
      tick();
      chk($sformatf("vec%0d.stall", k), stall_cycles, vecs[k].stall);
      chk($sformatf("vec%0d.flush", k), flush_count, vecs[k].flush);
      chk($sformatf("vec%0d.halted", k), halted, vecs[k].halted);
    end

    // Branch under a 3-cycle instruction-cache wait.
    do_reset();
    set_in(mk_in(5'b01010, 64'h100));
    #1; chk("icpend.c1.pc_en", pc_en, 0); chk("icpend.c1.if_id_flush", if_id_flush, 1);
    tick();
    for (int c = 0; c < 2; c++) begin
      set_in(mk_in(5'b01000, 64'h0));
      #2; chk("icpend.wait.pc_en", pc_en, 0); chk("icpend.wait.if_id_flush", if_id_flush, 1);
      tick();
    end
    set_in(mk_in(5'b00000, 64'h0));
    #2;
    chk("icpend.done.pc_en", pc_en, 1);
    chk("icpend.done.pc_redirect", pc_redirect, 1);
    chk("icpend.done.redirect_pc", redirect_pc, 64'h100);
    tick();
    chk("icpend.flush", flush_count, 1);
    chk("icpend.stall", stall_cycles, 3);
    #2; chk("icpend.run.pc_redirect", pc_redirect, 0); chk("icpend.run.if_id_flush", if_id_flush, 0);
    tick();

    // Branch caught under a 4-cycle data-cache wait.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(mk_in((c == 0) ? 5'b00110 : 5'b00100, (c == 0) ? 64'h200 : 64'h0));
      #2;
      chk("dcpend.pc_en", pc_en, 0);
      chk("dcpend.ex_mem_en", ex_mem_en, 0);
      chk("dcpend.mem_wb_en", mem_wb_en, 1);
      chk("dcpend.mem_wb_flush", mem_wb_flush, 1);
      tick();
    end
    set_in(mk_in(5'b00000, 64'h0));
    #2;
    chk("dcpend.done.pc_redirect", pc_redirect, 1);
    chk("dcpend.done.redirect_pc", redirect_pc, 64'h200);
    tick();
    chk("dcpend.flush", flush_count, 1);
    chk("dcpend.stall", stall_cycles, 4);

    // Halt, then everything is ignored and the counters freeze.
    do_reset();
    set_in(mk_in(5'b10000, 64'h0));
    tick();
    set_in(mk_in(5'b00001, 64'h0));
    #2; chk("halt.entry.mem_wb_en", mem_wb_en, 1); chk("halt.entry.id_ex_flush", id_ex_flush, 1);
    chk("halt.entry.pc_en", pc_en, 0);
    tick();
    chk("halt.halted", halted, 1);
    chk("halt.stall", stall_cycles, 2);
    for (int c = 0; c < 3; c++) begin
      set_in(mk_in(5'b11010, 64'h40));
      #2;
      chk("halt.pc_en", pc_en, 0);
      chk("halt.pc_redirect", pc_redirect, 0);
      chk("halt.ex_mem_en", ex_mem_en, 0);
      chk("halt.mem_wb_en", mem_wb_en, 0);
      tick();
    end
    chk("halt.stall.frozen", stall_cycles, 2);
    chk("halt.flush.frozen", flush_count, 0);
    chk("halt.still", halted, 1);

    // Asynchronous reset in the middle of a pending redirect.
    do_reset();
    set_in(mk_in(5'b01010, 64'h300));
    tick();
    set_in(mk_in(5'b01000, 64'h0));
    #1;
    reset = 1'b1;
    #1;
    chk("arst.pc_en", pc_en, 0);
    chk("arst.if_id_flush", if_id_flush, 0);
    chk("arst.id_ex_en", id_ex_en, 0);
    chk("arst.stall", stall_cycles, 0);
    chk("arst.flush", flush_count, 0);
    reset = 1'b0;
    set_in(mk_in(5'b00000, 64'h0));
    #1;
    chk("arst.run.pc_en", pc_en, 1);
    chk("arst.run.pc_redirect", pc_redirect, 0);
    chk("arst.run.if_id_flush", if_id_flush, 0);
    tick();

    // Randomized run against the reference model; counters are narrow so they wrap.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ri.lu  = ($urandom_range(0, 3) == 0);
      ri.ic  = ($urandom_range(0, 3) == 0);
      ri.dc  = ($urandom_range(0, 6) == 0);
      ri.br  = (st != 1) && ($urandom_range(0, 4) == 0);
      ri.hr  = ($urandom_range(0, 199) == 0);
      ri.tgt = {$urandom, $urandom};
      if (ri.br && st == 1) begin
        total++;
        $display("FAIL rand.branch_in_pend: got branch_taken=1, expected 0");
      end
      set_in(ri);
      #2;
      ev = model_ctl(ri);
      cmp_ctl("rand", ev);
      @(posedge clk);
      model_step(ri, ev);
      #1;
      chk("rand.halted", halted, (st == 2));
      chk("rand.stall", stall_cycles, mstall);
      chk("rand.flush", flush_count, mflush);
      if (st == 2 && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer side of the pipeline stall/flush interface for the 5-stage in-order core (IF, ID, EX, MEM, WB).
- Takes requests from four sources: the load-use stall request, instruction-cache wait, data-cache wait, and the EX-stage branch redirect.
- Arbitrates them and drives per-stage register enables and bubble/flush controls.
- Holds a branch redirect pending across instruction-cache stalls, enters a terminal halt state, and keeps stall/flush performance counters.

Parameters:
- XLEN, 64, PC/target width.
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- load_use_stall  in  1  load-use hazard request (ID must hold, EX gets bubble).
- icache_wait  in  1  fetch not complete this cycle.
- dcache_wait  in  1  MEM-stage access not complete this cycle.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- branch_target  in  XLEN  target PC, valid with branch_taken.
- halt_req  in  1  halting instruction (ecall) retiring in WB this cycle.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC loads redirect_pc instead of sequential PC (qualified by pc_en).
- redirect_pc  out  XLEN  redirect target.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load bubble (valid=0) into that register; overrides its enable.
- halted  out  1  core halted.
- stall_cycles  out  CNT_WIDTH  cycles with pc_en=0 while not halted.
- flush_count  out  CNT_WIDTH  number of redirects applied.

Behaviour:
- States: RUN, REDIR_PEND, HALTED. Registered: state, pend_target, counters.
- Reset: state=RUN, pend_target=0, counters=0. halted=0.
- Control outputs are combinational from the current inputs and state; all take effect at the next clk edge. Zero added latency.
- While reset is asserted, pc_en=0, all other enables=0, all flushes=0.
- Priority in RUN and REDIR_PEND, highest first:
  1. dcache_wait: all enables=0 except mem_wb; mem_wb_flush=1 so WB does not retire twice. branch_taken arriving in the same cycle is latched: go to REDIR_PEND with pend_target=branch_target, so the redirect is not lost. The EX branch is frozen and re-presents branch_taken; a re-presented branch_taken with an identical target is harmless.
  2. branch_taken, no dcache_wait:
     - icache_wait=0: pc_en=1, pc_redirect=1, redirect_pc=branch_target; if_id_flush=1, id_ex_flush=1; ex_mem_en=mem_wb_en=1; flush_count+1. load_use_stall is ignored because the ID instruction is wrong-path.
     - icache_wait=1: same flushes, pc_en=0, latch pend_target, go to REDIR_PEND, flush_count+1.
  3. load_use_stall: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  4. icache_wait: pc_en=0, if_id_flush=1, id_ex/ex_mem/mem_wb enables=1.
  5. none: all enables=1, no flush.
- In REDIR_PEND, redirect_pc=pend_target and if_id_flush=1 every cycle.
  - On the first cycle with icache_wait=0 and dcache_wait=0: pc_en=1, pc_redirect=1, return to RUN.
  - A new branch_taken in REDIR_PEND is impossible because EX holds a bubble. The bench asserts this never happens.
  - load_use_stall in REDIR_PEND is ignored (ID holds a bubble).
  - flush_count increments once per redirect, at entry, not again on completion.
- HALTED: entered on halt_req when dcache_wait=0, checked before all other rules. Entry cycle: mem_wb_en=1, all other enables=0, all flushes=1. Afterwards all enables=0 and halted=1 until reset. Counters freeze.
- stall_cycles increments each clock with pc_en=0 and state≠HALTED. Both counters wrap modulo 2^CNT_WIDTH.
- Asynchronous reset mid-stall or mid-REDIR_PEND discards pend_target and returns to RUN immediately.

Test Plan:
- load_use_stall=1 for 1 cycle, others 0 -> pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1; stall_cycles 0->1.
- branch_taken=1, target=0x8000_0040, load_use_stall=1 -> pc_en=1, pc_redirect=1, redirect_pc=0x8000_0040, if_id_flush=id_ex_flush=1, flush_count=1.
- branch_taken with icache_wait=1 held 3 cycles, target=0x100 -> REDIR_PEND 3 cycles, pc_en=0. Cycle icache_wait drops: pc_redirect=1, redirect_pc=0x100, state RUN; flush_count=1, stall_cycles=3.
- dcache_wait=1 for 4 cycles, branch_taken=1 (target 0x200) in first -> only mem_wb_en=1 with mem_wb_flush=1 for 4 cycles; redirect to 0x200 on cycle 5; flush_count=1.
- halt_req=1 -> next cycle halted=1, all enables 0; further load_use/branch ignored; counters frozen.
- Assert reset asynchronously during REDIR_PEND -> outputs go to reset values without a clk edge; after release, state RUN, counters 0.
